ca_run_ctrl: RTL

Sequencer and row-capture stage wrapped around the 32-cell cellular automaton array. It accepts a run command (rule, seed, boundary bits, generation count, sample stride) over a valid/ready handshake. It loads the seed into the array with a one-cycle set_state pulse, then lets the array free-run one generation per clock. It samples every STRIDE-th generation row into a small FIFO and streams the samples out over a valid/ready interface.

---
 rtl/ca_pkg.sv | 17 +
 rtl/ca_run_ctrl_if.sv | 36 +++
 rtl/ca_row_fifo.sv | 60 ++++++
 rtl/ca_run_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: shared constants and types for the CA run controller slice.
//   CA_WIDTH     cells per row (must match the array)
//   CA_GEN_W     generation counter width
//   ctrl_state_e sequencer states
//   row_t        one sampled row as stored in the row FIFO
package ca_pkg;
  localparam int CA_WIDTH = 32;
  localparam int CA_GEN_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} ctrl_state_e;

  typedef struct packed {
    logic [CA_WIDTH-1:0] data;
    logic [CA_GEN_W-1:0] gen;
    logic                last;
  } row_t;
endpackage

// File: rtl/ca_run_ctrl_if.sv
// ca_run_ctrl_if: run-command and sampled-row streams of ca_run_ctrl.
//   cfg_*  command channel (valid/ready), driven by the host
//   row_*  sampled-row channel (valid/ready), driven by the controller
//   slave  modport: controller side; master modport: host/consumer side
interface ca_run_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int GEN_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [7:0]       cfg_rule;
  logic [WIDTH-1:0] cfg_seed;
  logic             cfg_left;
  logic             cfg_right;
  logic [GEN_W-1:0] cfg_gens;
  logic [7:0]       cfg_stride;
  logic             row_valid;
  logic             row_ready;
  logic [WIDTH-1:0] row_data;
  logic [GEN_W-1:0] row_gen;
  logic             row_last;

  modport slave (
    input  cfg_valid, cfg_rule, cfg_seed, cfg_left, cfg_right, cfg_gens, cfg_stride,
    output cfg_ready,
    output row_valid, row_data, row_gen, row_last,
    input  row_ready
  );

  modport master (
    output cfg_valid, cfg_rule, cfg_seed, cfg_left, cfg_right, cfg_gens, cfg_stride,
    input  cfg_ready,
    input  row_valid, row_data, row_gen, row_last,
    output row_ready
  );
endinterface

// File: rtl/ca_row_fifo.sv
// ca_row_fifo: synchronous show-ahead FIFO of row_t.
//   push/wr_data  write request; accepted when not full or when popping
//   pop           read request; ignored when empty
//   rd_data       head entry, valid whenever empty=0
//   full/empty/count  occupancy, count-based
module ca_row_fifo
  import ca_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  row_t                     wr_data,
  input  logic                     pop,
  output row_t                     rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  row_t              mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  // Full with a same-cycle pop still has room: the head slot frees at this edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_ok) mem_q[wptr_q] <= wr_data;
    end
  end
endmodule

// File: rtl/ca_run_ctrl.sv
// ca_run_ctrl: sequencer and row capture around the CA array.
//   io          command in (cfg_*), sampled rows out (row_*)
//   rule/left/right/state/set_state  registered controls to the array
//   ca_out      current array row
//   busy        FSM not idle; done one-cycle pulse at end of run
//   drop_count  captures lost to a full FIFO, saturating, cleared per command
module ca_run_ctrl
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH,
  parameter int DEPTH = 4,
  parameter int GEN_W = CA_GEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  ca_run_ctrl_if.slave     io,
  output logic [7:0]       rule,
  output logic             left,
  output logic             right,
  output logic [WIDTH-1:0] state,
  output logic             set_state,
  input  logic [WIDTH-1:0] ca_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       drop_count
);
  ctrl_state_e      fsm_q, fsm_d;
  logic [7:0]       rule_q, rule_d, stride_m1_q, stride_m1_d, stride_cnt_q, stride_cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             left_q, left_d, right_q, right_d, set_state_q, set_state_d, done_q, done_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [GEN_W-1:0] gens_q, gens_d, gen_cnt_q, gen_cnt_d;

  logic             push, is_last, row_pop, fifo_accept, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  row_t             row_in, row_head;

  assign is_last     = (gen_cnt_q == gens_q);
  assign row_in      = '{data: ca_out, gen: gen_cnt_q, last: is_last};
  assign row_pop     = io.row_ready && !fifo_empty;
  assign fifo_accept = !fifo_full || row_pop;

  always_comb begin
    fsm_d        = fsm_q;
    rule_d       = rule_q;
    left_d       = left_q;
    right_d      = right_q;
    seed_d       = seed_q;
    gens_d       = gens_q;
    stride_m1_d  = stride_m1_q;
    stride_cnt_d = stride_cnt_q;
    gen_cnt_d    = gen_cnt_q;
    drop_d       = drop_q;
    set_state_d  = 1'b0;
    done_d       = 1'b0;
    push         = 1'b0;
    unique case (fsm_q)
      IDLE: if (io.cfg_valid) begin
        rule_d      = io.cfg_rule;
        left_d      = io.cfg_left;
        right_d     = io.cfg_right;
        seed_d      = io.cfg_seed;
        gens_d      = io.cfg_gens;
        // stride 0 and 1 both sample every generation
        stride_m1_d = (io.cfg_stride == 8'd0) ? 8'd0 : io.cfg_stride - 8'd1;
        drop_d      = 8'd0;
        set_state_d = 1'b1;  // high for the whole LOAD cycle
        fsm_d       = LOAD;
      end
      LOAD: begin
        gen_cnt_d    = '0;
        stride_cnt_d = 8'd0;
        fsm_d        = RUN;
      end
      RUN: begin
        push = (stride_cnt_q == 8'd0) || is_last;
        if (push && !fifo_accept && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (is_last) begin
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          gen_cnt_d    = gen_cnt_q + 1'b1;
          stride_cnt_d = (stride_cnt_q == stride_m1_q) ? 8'd0 : stride_cnt_q + 8'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      rule_q       <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      seed_q       <= '0;
      gens_q       <= '0;
      stride_m1_q  <= '0;
      stride_cnt_q <= '0;
      gen_cnt_q    <= '0;
      drop_q       <= '0;
      set_state_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      rule_q       <= rule_d;
      left_q       <= left_d;
      right_q      <= right_d;
      seed_q       <= seed_d;
      gens_q       <= gens_d;
      stride_m1_q  <= stride_m1_d;
      stride_cnt_q <= stride_cnt_d;
      gen_cnt_q    <= gen_cnt_d;
      drop_q       <= drop_d;
      set_state_q  <= set_state_d;
      done_q       <= done_d;
    end
  end

  ca_row_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (row_in),
    .pop     (row_pop),
    .rd_data (row_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign io.cfg_ready = (fsm_q == IDLE);
  assign io.row_valid = (fifo_count != '0);
  assign io.row_data  = row_head.data;
  assign io.row_gen   = row_head.gen;
  assign io.row_last  = row_head.last;
  assign rule         = rule_q;
  assign left         = left_q;
  assign right        = right_q;
  assign state        = seed_q;
  assign set_state    = set_state_q;
  assign busy         = (fsm_q != IDLE);
  assign done         = done_q;
  assign drop_count   = drop_q;
endmodule
